mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Memory-stage data-memory unit for the 5-stage pipeline. Sits between the EX/MEM register and the MEM/WB register. It takes the byte address (ALU result) and the store data and performs byte, halfword or word loads and stores against an internal word-organised RAM with a configurable access latency. It stalls the upstream stages while an access is in flight and presents sign- or zero-extended load data to MEM/WB in the completion cycle.

## Interface
- DEPTH_WORDS, 512: RAM depth in 32-bit words; must be a power of two.
- LATENCY, 2: cycles per memory access, including the completion cycle; must be at least 1.

- CLOCK  in  1  pipeline clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- MemRead_in  in  1  load request, from EX/MEM.
- MemWrite_in  in  1  store request, from EX/MEM.
- Size_in  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word.
- Unsigned_in  in  1  load extension: 1 zero-extends, 0 sign-extends.
- Address_in  in  32  byte address.
- WriteData_in  in  32  store data; the value sits in the low bits for byte and half stores.
- ReadData_out  out  32  extended load data, valid in the completion cycle; goes to MEM/WB ReadData_in.
- Stall_out  out  1  freeze PC, IF/ID, ID/EX and EX/MEM; insert a bubble into MEM/WB.
- Misalign_out  out  1  misaligned access detected this cycle.

## Operation
- Request: MemRead_in or MemWrite_in is high. If both are high, the access is a store, and ReadData_out is 0.
- Word index is Address_in[log2(DEPTH_WORDS)+1:2]. Higher address bits are ignored, so addresses wrap modulo the RAM size.
- Byte lanes are little-endian: byte lane k is bits 8k+7:8k, with k = Address_in[1:0].
- Half lane is selected by Address_in[1].
- Misaligned: a half access with Address_in[0]=1, or a word access with Address_in[1:0]≠0.
  - Misalign_out goes high combinationally in that cycle.
  - No stall, no RAM write, ReadData_out=0.
  - The FSM stays in IDLE.
- Stores write only the selected lanes. Byte store uses WriteData_in[7:0]; half store uses WriteData_in[15:0]. Unselected lanes are preserved.
- Loads extract the selected lane, then sign- or zero-extend it to 32 bits according to Unsigned_in.
- FSM has two states, IDLE and BUSY, and a counter cnt of width clog2(LATENCY)+1.
  - IDLE with an aligned request:
    - LATENCY=1: this cycle is the completion cycle; stay in IDLE.
    - Otherwise: go to BUSY with cnt=1.
  - BUSY, request still high, cnt<LATENCY-1: cnt increments.
  - BUSY, request still high, cnt==LATENCY-1: this is the completion cycle. Go to IDLE, cnt=0.
  - BUSY, request dropped: abort. Go to IDLE with no write. This is a protocol error, but the behaviour is defined.
- Stall_out = aligned request AND NOT completion cycle. It is combinational and high for exactly LATENCY-1 cycles per access.
- Completion cycle:
  - Stall_out=0.
  - A store commits to RAM on the closing edge, exactly once.
  - ReadData_out reflects RAM contents before any same-edge write.
- Outside the completion cycle, ReadData_out=0.
- Back-to-back requests: a request seen in IDLE on the cycle after a completion starts a new access. There are no idle cycles in between.
- RAM contents are not cleared by RESET. Simulation initialises them to 0.

## Timing
- While RESET is high: state IDLE, cnt=0. Stall_out=0, Misalign_out=0 and ReadData_out=0, with no RAM write.
- Reset mid-access: the access is discarded and any pending store is never written. The FSM is in IDLE on the first cycle after RESET falls.
- Access accepted in cycle T completes in cycle T+LATENCY-1. MEM/WB captures ReadData_out at the end of that cycle.
- Inputs must be held stable while Stall_out=1. Upstream registers guarantee this.
- Outputs have no registered latency beyond the FSM. Stall_out, ReadData_out and Misalign_out are combinational from state and inputs.

## Test plan
- Word store then load, LATENCY=2:
  - sw 0xDEADBEEF to address 0x10: Stall_out high 1 cycle.
  - lw from 0x10: in the completion cycle ReadData_out=0xDEADBEEF and Stall_out=0.
- Byte and half extension:
  - Store word 0x80FF7F01 to 0x20.
  - lb 0x23 -> 0xFFFFFF80.
  - lbu 0x23 -> 0x00000080.
  - lh 0x22 -> 0xFFFF80FF.
  - lhu 0x20 -> 0x00007F01.
- Partial store preserves lanes:
  - Word 0x11223344 at 0x30, then sb 0xAA to 0x31 -> lw 0x30 = 0x1122AA44.
  - Then sh 0xBEEF to 0x32 -> lw 0x30 = 0xBEEFAA44.
- Misalign:
  - lw 0x41: Misalign_out=1, Stall_out=0, ReadData_out=0.
  - sh 0x43 with data 0x1234: RAM word at 0x40 unchanged.
- Reset mid-access, LATENCY=4:
  - sw 0x55 to 0x50; assert RESET in the second stall cycle.
  - Stall_out drops while RESET is high; lw 0x50 afterwards returns the old value 0.
- Latency and wrap, LATENCY=3, DEPTH_WORDS=512:
  - Back-to-back lw/lw: Stall_out pattern 1,1,0,1,1,0.
  - sw to 0x800 aliases word 0: lw 0x0 returns the stored value.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage
//   Memory-stage data-memory unit for the 5-stage pipeline. It performs byte,
//   halfword and word loads/stores against an internal word-organised RAM
//   with a fixed multi-cycle access latency. Upstream stages are stalled while
//   an access is in flight. Load data is sign- or zero-extended and presented
//   to MEM/WB in the completion cycle.
//
// Parameters
//   DEPTH_WORDS  RAM depth in 32-bit words (power of two)
//   LATENCY      cycles per access including the completion cycle (>= 1)
//
// Ports
//   CLOCK         pipeline clock, rising edge
//   RESET         synchronous active-high reset (control state only)
//   MemRead_in    load request
//   MemWrite_in   store request (wins when both requests are high)
//   Size_in       00 byte, 01 half, 10/11 word
//   Unsigned_in   1 zero-extends, 0 sign-extends load data
//   Address_in    byte address; bits above the RAM index wrap
//   WriteData_in  store data, right-aligned for byte/half stores
//   ReadData_out  extended load data, non-zero only in a load completion cycle
//   Stall_out     freeze upstream while an aligned access is not yet complete
//   Misalign_out  misaligned half/word access seen this cycle
module mem_access_stage #(
  parameter int DEPTH_WORDS = 512,
  parameter int LATENCY     = 2
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic [1:0]  Size_in,
  input  logic        Unsigned_in,
  input  logic [31:0] Address_in,
  input  logic [31:0] WriteData_in,
  output logic [31:0] ReadData_out,
  output logic        Stall_out,
  output logic        Misalign_out
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(LATENCY) + 1;
  localparam logic [CW-1:0] LAST = CW'(LATENCY - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  // Extract the addressed lane and extend it to 32 bits.
  function automatic logic [31:0] extendLoad(
    input logic [31:0] word,
    input logic [1:0]  size,
    input logic [1:0]  lane,
    input logic        zeroExt
  );
    logic signed [7:0]  byteVal;
    logic signed [15:0] halfVal;
    logic signed [31:0] wide;
    byteVal = word[{lane, 3'b000} +: 8];
    halfVal = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00: begin
        if (zeroExt) wide = {24'd0, byteVal};
        else         wide = 32'(byteVal);
      end
      2'b01: begin
        if (zeroExt) wide = {16'd0, halfVal};
        else         wide = 32'(halfVal);
      end
      default: wide = word;
    endcase
    return wide;
  endfunction

  // Merge store data into the old word, touching only the selected lanes.
  function automatic logic [31:0] mergeStore(
    input logic [31:0] oldWord,
    input logic [31:0] data,
    input logic [1:0]  size,
    input logic [1:0]  lane
  );
    logic [31:0] merged;
    merged = oldWord;
    case (size)
      2'b00: merged[{lane, 3'b000} +: 8] = data[7:0];
      2'b01: begin
        if (lane[1]) merged[31:16] = data[15:0];
        else         merged[15:0]  = data[15:0];
      end
      default: merged = data;
    endcase
    return merged;
  endfunction

  logic [31:0]   mem [DEPTH_WORDS];
  state_t        state_p0;
  logic [CW-1:0] cnt_p0;

  logic          request;
  logic          isStore;
  logic          misalign;
  logic          aligned;
  logic          complete;
  logic [1:0]    lane;
  logic [AW-1:0] wordIdx;
  logic          unusedAddrBits;

  assign lane           = Address_in[1:0];
  assign wordIdx        = Address_in[AW+1:2];
  assign unusedAddrBits = ^Address_in[31:AW+2];
  assign request        = MemRead_in | MemWrite_in;
  assign isStore        = MemWrite_in;

  always_comb begin
    misalign = 1'b0;
    if (request) begin
      if (Size_in == 2'b01)  misalign = lane[0];
      else if (Size_in[1])   misalign = (lane != 2'b00);
    end
    // Reset masks every request so nothing is stalled, flagged or written.
    aligned  = request & ~misalign & ~RESET;
    complete = 1'b0;
    if (LATENCY == 1) complete = aligned && (state_p0 == IDLE);
    else              complete = aligned && (state_p0 == BUSY) && (cnt_p0 == LAST);
  end

  assign Stall_out    = aligned & ~complete;
  assign Misalign_out = misalign & ~RESET;
  // RAM read is asynchronous so the pre-write contents appear in the same cycle.
  assign ReadData_out = (complete && !isStore)
                        ? extendLoad(mem[wordIdx], Size_in, lane, Unsigned_in)
                        : 32'd0;

  // ---- stage p0: access sequencing ----
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_p0 <= IDLE;
      cnt_p0   <= '0;
    end else begin
      case (state_p0)
        IDLE: begin
          if (aligned && LATENCY > 1) begin
            state_p0 <= BUSY;
            cnt_p0   <= CW'(1);
          end
        end
        BUSY: begin
          // A dropped request aborts; the completion cycle returns to IDLE.
          if (!aligned || cnt_p0 == LAST) begin
            state_p0 <= IDLE;
            cnt_p0   <= '0;
          end else begin
            cnt_p0 <= cnt_p0 + CW'(1);
          end
        end
        default: begin
          state_p0 <= IDLE;
          cnt_p0   <= '0;
        end
      endcase
    end
  end

  // ---- stage p0: RAM commit on the closing edge of the completion cycle ----
  always_ff @(posedge CLOCK) begin
    if (complete && isStore)
      mem[wordIdx] <= mergeStore(mem[wordIdx], WriteData_in, Size_in, lane);
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: three instances (LATENCY 2, 4, 3) share the
// data/address/reset inputs; only the selected instance sees a request.
// A behavioural model (byte-lane arithmetic over a word array plus an
// elapsed-cycle count per held access) predicts every output each cycle.
module tb_mem_access_stage;

  localparam int LAT [3] = '{2, 4, 3};

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        rdReq, wrReq, uns;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  int          cur;

  logic        memRd [3];
  logic        memWr [3];
  logic [31:0] rdata [3];
  logic        stall [3];
  logic        mis   [3];

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] modelMem [3][512];
  int          hold [3];

  always #5 CLOCK = ~CLOCK;

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : gInst
      assign memRd[g] = rdReq && (cur == g);
      assign memWr[g] = wrReq && (cur == g);
      mem_access_stage #(
        .DEPTH_WORDS(512),
        .LATENCY(g == 0 ? 2 : (g == 1 ? 4 : 3))
      ) dut (
        .CLOCK(CLOCK),
        .RESET(RESET),
        .MemRead_in(memRd[g]),
        .MemWrite_in(memWr[g]),
        .Size_in(size),
        .Unsigned_in(uns),
        .Address_in(addr),
        .WriteData_in(wdata),
        .ReadData_out(rdata[g]),
        .Stall_out(stall[g]),
        .Misalign_out(mis[g])
      );
    end
  endgenerate

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic isMis(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b01) return (a % 2) != 0;
    if (sz[1])       return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic int idx(input logic [31:0] a);
    return int'((a / 4) % 512);
  endfunction

  function automatic logic [31:0] loadVal(input logic [31:0] w, input logic [1:0] sz,
                                          input logic [31:0] a, input logic u);
    int sh;
    logic [31:0] v;
    if (sz == 2'b00) begin
      sh = int'(a % 4) * 8;
      v = (w >> sh) & 32'hFF;
      if (!u && v >= 128) v = v + 32'hFFFFFF00;
    end else if (sz == 2'b01) begin
      sh = int'((a / 2) % 2) * 16;
      v = (w >> sh) & 32'hFFFF;
      if (!u && v >= 32768) v = v + 32'hFFFF0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] storeVal(input logic [31:0] old, input logic [31:0] d,
                                           input logic [1:0] sz, input logic [31:0] a);
    int sh;
    logic [31:0] mask;
    if (sz == 2'b00) begin
      sh = int'(a % 4) * 8;
      mask = 32'hFF << sh;
    end else if (sz == 2'b01) begin
      sh = int'((a / 2) % 2) * 16;
      mask = 32'hFFFF << sh;
    end else begin
      sh = 0;
      mask = 32'hFFFFFFFF;
    end
    return (old & ~mask) | ((d << sh) & mask);
  endfunction

  function automatic void modelOut(input int i, output logic al, output logic comp,
                                   output logic eMis);
    logic req;
    req  = memRd[i] | memWr[i];
    eMis = req && !RESET && isMis(size, addr);
    al   = req && !RESET && !isMis(size, addr);
    comp = al && (hold[i] == LAT[i] - 1);
  endfunction

  // Compare every instance's outputs on every falling edge.
  always @(negedge CLOCK) begin
    logic al, comp, em;
    logic [31:0] eRd;
    for (int i = 0; i < 3; i++) begin
      modelOut(i, al, comp, em);
      eRd = (comp && !memWr[i]) ? loadVal(modelMem[i][idx(addr)], size, addr, uns) : 32'd0;
      chk($sformatf("inst%0d Stall_out", i), 32'(stall[i]), 32'(al && !comp));
      chk($sformatf("inst%0d Misalign_out", i), 32'(mis[i]), 32'(em));
      chk($sformatf("inst%0d ReadData_out", i), rdata[i], eRd);
    end
  end

  // Advance the model on the rising edge, using the inputs the DUT samples.
  always @(posedge CLOCK) begin
    logic al, comp, em;
    for (int i = 0; i < 3; i++) begin
      modelOut(i, al, comp, em);
      if (!al) hold[i] = 0;
      else if (comp) begin
        hold[i] = 0;
        if (memWr[i])
          modelMem[i][idx(addr)] = storeVal(modelMem[i][idx(addr)], wdata, size, addr);
      end else begin
        hold[i] = hold[i] + 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic doAccess(input int i, input logic r, input logic w, input logic [1:0] sz,
                          input logic u, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] data, output int stalls, output logic misSeen);
    int n;
    cur = i; rdReq = r; wrReq = w; size = sz; uns = u; addr = a; wdata = d;
    stalls = 0;
    n = 0;
    @(negedge CLOCK);
    while (stall[i] && n < 20) begin
      stalls++;
      n++;
      @(posedge CLOCK); #1;
      @(negedge CLOCK);
    end
    if (n >= 20) begin
      miscompares++;
      $display("FAIL inst%0d access timeout: stall still %b after %0d cycles", i, stall[i], n);
    end
    data = rdata[i];
    misSeen = mis[i];
    @(posedge CLOCK); #1;
    rdReq = 1'b0;
    wrReq = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int st;
    logic m;
    for (int i = 0; i < 3; i++) begin
      hold[i] = 0;
      for (int j = 0; j < 512; j++) modelMem[i][j] = 32'd0;
    end
    // Reset with a misaligned store pending: nothing may be flagged.
    RESET = 1'b1; cur = 0; rdReq = 1'b0; wrReq = 1'b1; size = 2'b10; uns = 1'b0;
    addr = 32'h41; wdata = 32'h0;
    repeat (3) @(posedge CLOCK);
    #1;
    @(negedge CLOCK);
    chk("reset Misalign_out", 32'(mis[0]), 32'd0);
    chk("reset Stall_out", 32'(stall[0]), 32'd0);
    @(posedge CLOCK); #1;
    RESET = 1'b0; wrReq = 1'b0;
    @(posedge CLOCK); #1;

    // Word store then load, LATENCY=2
    doAccess(0, 0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, d, st, m);
    chk("sw stalls", st, 1);
    doAccess(0, 1, 0, 2'b10, 0, 32'h10, 32'h0, d, st, m);
    chk("lw 0x10", d, 32'hDEADBEEF);
    chk("lw stalls", st, 1);

    // Byte/half extension
    doAccess(0, 0, 1, 2'b10, 0, 32'h20, 32'h80FF7F01, d, st, m);
    doAccess(0, 1, 0, 2'b00, 0, 32'h23, 32'h0, d, st, m);
    chk("lb 0x23", d, 32'hFFFFFF80);
    doAccess(0, 1, 0, 2'b00, 1, 32'h23, 32'h0, d, st, m);
    chk("lbu 0x23", d, 32'h00000080);
    doAccess(0, 1, 0, 2'b01, 0, 32'h22, 32'h0, d, st, m);
    chk("lh 0x22", d, 32'hFFFF80FF);
    doAccess(0, 1, 0, 2'b01, 1, 32'h20, 32'h0, d, st, m);
    chk("lhu 0x20", d, 32'h00007F01);

    // Partial stores preserve other lanes
    doAccess(0, 0, 1, 2'b10, 0, 32'h30, 32'h11223344, d, st, m);
    doAccess(0, 0, 1, 2'b00, 0, 32'h31, 32'hFFFFFFAA, d, st, m);
    doAccess(0, 1, 0, 2'b10, 0, 32'h30, 32'h0, d, st, m);
    chk("lw after sb", d, 32'h1122AA44);
    doAccess(0, 0, 1, 2'b01, 0, 32'h32, 32'h0000BEEF, d, st, m);
    doAccess(0, 1, 0, 2'b10, 0, 32'h30, 32'h0, d, st, m);
    chk("lw after sh", d, 32'hBEEFAA44);

    // Misalignment
    doAccess(0, 1, 0, 2'b10, 0, 32'h41, 32'h0, d, st, m);
    chk("lw 0x41 Misalign_out", 32'(m), 32'd1);
    chk("lw 0x41 stalls", st, 0);
    chk("lw 0x41 data", d, 32'd0);
    doAccess(0, 0, 1, 2'b10, 0, 32'h40, 32'hCAFEF00D, d, st, m);
    doAccess(0, 0, 1, 2'b01, 0, 32'h43, 32'h00001234, d, st, m);
    chk("sh 0x43 Misalign_out", 32'(m), 32'd1);
    doAccess(0, 1, 0, 2'b10, 0, 32'h40, 32'h0, d, st, m);
    chk("word 0x40 unchanged", d, 32'hCAFEF00D);

    // Reset mid-access, LATENCY=4
    cur = 1; rdReq = 1'b0; wrReq = 1'b1; size = 2'b10; uns = 1'b0;
    addr = 32'h50; wdata = 32'h55;
    @(negedge CLOCK);
    chk("L4 first stall", 32'(stall[1]), 32'd1);
    @(posedge CLOCK); #1;
    RESET = 1'b1;
    @(negedge CLOCK);
    chk("L4 stall under reset", 32'(stall[1]), 32'd0);
    @(posedge CLOCK); #1;
    RESET = 1'b0; wrReq = 1'b0;
    doAccess(1, 1, 0, 2'b10, 0, 32'h50, 32'h0, d, st, m);
    chk("L4 lw 0x50 after reset", d, 32'h0);
    chk("L4 lw stalls", st, 3);

    // Latency 3: wrap and back-to-back loads
    doAccess(2, 0, 1, 2'b10, 0, 32'h800, 32'h12345678, d, st, m);
    chk("L3 sw stalls", st, 2);
    doAccess(2, 1, 0, 2'b10, 0, 32'h0, 32'h0, d, st, m);
    chk("L3 lw 0x0 aliased", d, 32'h12345678);
    chk("L3 lw1 stalls", st, 2);
    doAccess(2, 1, 0, 2'b10, 0, 32'h800, 32'h0, d, st, m);
    chk("L3 lw 0x800", d, 32'h12345678);
    chk("L3 lw2 stalls", st, 2);

    // Randomized traffic, checked cycle by cycle by the model
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 60; k++) begin
        logic r, w, u;
        logic [1:0] sz;
        logic [31:0] a;
        r  = 1'($urandom_range(0, 1));
        w  = 1'($urandom_range(0, 1));
        if (!r && !w) r = 1'b1;
        sz = 2'($urandom_range(0, 3));
        u  = 1'($urandom_range(0, 1));
        a  = ($urandom & 32'hFFFFF800) | (32'($urandom_range(0, 15)) << 2)
             | 32'($urandom_range(0, 3));
        if (sz != 2'b00 && $urandom_range(0, 3) != 0) a = a & 32'hFFFFFFFC;
        if (k % 9 == 4) begin
          // Drop the request after one cycle: aborted access, no write.
          cur = i; rdReq = r; wrReq = w; size = sz; uns = u; addr = a; wdata = $urandom;
          @(posedge CLOCK); #1;
          rdReq = 1'b0; wrReq = 1'b0;
          @(posedge CLOCK); #1;
        end else begin
          doAccess(i, r, w, sz, u, a, $urandom, d, st, m);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge CLOCK); #1;
          end
        end
      end
    end

    @(posedge CLOCK); #1;
    @(negedge CLOCK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
